// File: rtl/video_pkg.sv
// Shared video constants and the ball sequencer state type for the ball renderer slice.
// Optional feature macro: BALL_HIT_COUNT_EN (bounce counter output on ball_renderer).
package video_pkg;

    localparam int unsigned H_DISPLAY_DEFAULT = 640;
    localparam int unsigned V_DISPLAY_DEFAULT = 480;

    localparam logic [2:0] RGB_BLACK = 3'b000;
    localparam logic [2:0] RGB_WHITE = 3'b111;
    localparam logic [2:0] RGB_GREEN = 3'b010;

    typedef enum logic [1:0] {
        IDLE,
        MOVE,
        BOUNCE
    } ball_state_t;

endpackage

// File: rtl/ball_motion.sv
// Ball motion: frame-tick detect, IDLE/MOVE/BOUNCE sequencer, position and velocity state.
// With BALL_HIT_COUNT_EN defined, also a saturating bounce counter on hit_count.
module ball_motion
    import video_pkg::*;
#(
    parameter int unsigned POS_W     = 10,
    parameter int unsigned H_DISPLAY = H_DISPLAY_DEFAULT,
    parameter int unsigned V_DISPLAY = V_DISPLAY_DEFAULT,
    parameter int unsigned BALL_SIZE = 16,
    parameter int unsigned X_SPEED   = 2,
    parameter int unsigned Y_SPEED   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [POS_W-1:0] hpos,
    input  logic [POS_W-1:0] vpos,
    output logic [POS_W-1:0] ball_x,
    output logic [POS_W-1:0] ball_y
`ifdef BALL_HIT_COUNT_EN
    ,
    output logic [7:0]       hit_count
`endif
);

    localparam logic [POS_W-1:0] X_INIT = POS_W'(H_DISPLAY / 2 - BALL_SIZE / 2);
    localparam logic [POS_W-1:0] Y_INIT = POS_W'(V_DISPLAY / 2 - BALL_SIZE / 2);
    localparam logic [POS_W-1:0] X_MAX  = POS_W'(H_DISPLAY - BALL_SIZE);
    localparam logic [POS_W-1:0] Y_MAX  = POS_W'(V_DISPLAY - BALL_SIZE);
    localparam logic [POS_W-1:0] TICK_V = POS_W'(V_DISPLAY);

    localparam logic signed [POS_W:0] X_MAX_S = $signed({1'b0, X_MAX});
    localparam logic signed [POS_W:0] Y_MAX_S = $signed({1'b0, Y_MAX});
    localparam logic signed [POS_W:0] X_STEP  = (POS_W+1)'(X_SPEED);
    localparam logic signed [POS_W:0] Y_STEP  = (POS_W+1)'(Y_SPEED);

    ball_state_t           state_q, state_d;
    logic [POS_W-1:0]      ball_x_q, ball_x_d, ball_y_q, ball_y_d;
    logic                  x_neg_q, x_neg_d, y_neg_q, y_neg_d;
    logic signed [POS_W:0] nx_q, nx_d, ny_q, ny_d;
    logic                  tick, x_lo, x_hi, y_lo, y_hi;

    // First line of vertical blanking; hpos==0 lasts one pixel so this is a 1-cycle pulse.
    assign tick = (hpos == '0) && (vpos == TICK_V);

    // Landing exactly on 0 or the max edge is not a bounce.
    assign x_lo = nx_q[POS_W];
    assign x_hi = nx_q > X_MAX_S;
    assign y_lo = ny_q[POS_W];
    assign y_hi = ny_q > Y_MAX_S;

    always_comb begin
        state_d  = state_q;
        ball_x_d = ball_x_q;
        ball_y_d = ball_y_q;
        x_neg_d  = x_neg_q;
        y_neg_d  = y_neg_q;
        nx_d     = nx_q;
        ny_d     = ny_q;
        case (state_q)
            IDLE: begin
                if (tick) state_d = MOVE;
            end
            MOVE: begin
                nx_d    = $signed({1'b0, ball_x_q}) + (x_neg_q ? -X_STEP : X_STEP);
                ny_d    = $signed({1'b0, ball_y_q}) + (y_neg_q ? -Y_STEP : Y_STEP);
                state_d = BOUNCE;
            end
            BOUNCE: begin
                if (x_lo) begin
                    ball_x_d = '0;
                    x_neg_d  = 1'b0;
                end else if (x_hi) begin
                    ball_x_d = X_MAX;
                    x_neg_d  = 1'b1;
                end else begin
                    ball_x_d = nx_q[POS_W-1:0];
                end
                if (y_lo) begin
                    ball_y_d = '0;
                    y_neg_d  = 1'b0;
                end else if (y_hi) begin
                    ball_y_d = Y_MAX;
                    y_neg_d  = 1'b1;
                end else begin
                    ball_y_d = ny_q[POS_W-1:0];
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            ball_x_q <= X_INIT;
            ball_y_q <= Y_INIT;
            x_neg_q  <= 1'b0;
            y_neg_q  <= 1'b0;
            nx_q     <= '0;
            ny_q     <= '0;
        end else begin
            state_q  <= state_d;
            ball_x_q <= ball_x_d;
            ball_y_q <= ball_y_d;
            x_neg_q  <= x_neg_d;
            y_neg_q  <= y_neg_d;
            nx_q     <= nx_d;
            ny_q     <= ny_d;
        end
    end

    assign ball_x = ball_x_q;
    assign ball_y = ball_y_q;

`ifdef BALL_HIT_COUNT_EN
    logic [7:0] hit_q, hit_d;

    // A corner hit bounces both axes but counts once.
    always_comb begin
        hit_d = hit_q;
        if ((state_q == BOUNCE) && (x_lo || x_hi || y_lo || y_hi) && (hit_q != 8'hFF))
            hit_d = hit_q + 8'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) hit_q <= '0;
        else       hit_q <= hit_d;
    end

    assign hit_count = hit_q;
`endif

endmodule

// File: rtl/ball_renderer.sv
// Pixel stage after the sync generator: 2-cycle pixel pipe, sync re-alignment, colour mux.
// Defining BALL_HIT_COUNT_EN adds the hit_count output from the motion block.
module ball_renderer
    import video_pkg::*;
#(
    parameter int unsigned POS_W      = 10,
    parameter int unsigned H_DISPLAY  = H_DISPLAY_DEFAULT,
    parameter int unsigned V_DISPLAY  = V_DISPLAY_DEFAULT,
    parameter int unsigned BALL_SIZE  = 16,
    parameter int unsigned X_SPEED    = 2,
    parameter int unsigned Y_SPEED    = 1,
    parameter logic [2:0]  BALL_RGB   = RGB_WHITE,
    parameter logic [2:0]  BORDER_RGB = RGB_GREEN
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [POS_W-1:0] hpos,
    input  logic [POS_W-1:0] vpos,
    input  logic             display_on,
    input  logic             hsync_in,
    input  logic             vsync_in,
    output logic             hsync,
    output logic             vsync,
    output logic [2:0]       rgb,
    output logic [POS_W-1:0] ball_x,
    output logic [POS_W-1:0] ball_y
`ifdef BALL_HIT_COUNT_EN
    ,
    output logic [7:0]       hit_count
`endif
);

    localparam logic [POS_W-1:0] SIZE   = POS_W'(BALL_SIZE);
    localparam logic [POS_W-1:0] H_LAST = POS_W'(H_DISPLAY - 1);
    localparam logic [POS_W-1:0] V_LAST = POS_W'(V_DISPLAY - 1);

    logic             in_x_q, in_x_d, in_y_q, in_y_d;
    logic             border_q, border_d, disp_q, disp_d;
    logic             hsync_q, hsync_d, vsync_q, vsync_d;
    logic [2:0]       rgb_q, rgb_d;
    logic [POS_W-1:0] off_x, off_y;

    ball_motion #(
        .POS_W     (POS_W),
        .H_DISPLAY (H_DISPLAY),
        .V_DISPLAY (V_DISPLAY),
        .BALL_SIZE (BALL_SIZE),
        .X_SPEED   (X_SPEED),
        .Y_SPEED   (Y_SPEED)
    ) u_motion (
        .clk       (clk),
        .reset     (reset),
        .hpos      (hpos),
        .vpos      (vpos),
        .ball_x    (ball_x),
        .ball_y    (ball_y)
`ifdef BALL_HIT_COUNT_EN
        ,
        .hit_count (hit_count)
`endif
    );

    always_comb begin
        // Beam left of the ball wraps to a large offset and so misses.
        off_x    = hpos - ball_x;
        off_y    = vpos - ball_y;
        in_x_d   = off_x < SIZE;
        in_y_d   = off_y < SIZE;
        border_d = (hpos == '0) || (hpos == H_LAST) || (vpos == '0) || (vpos == V_LAST);
        disp_d   = display_on;
        hsync_d  = hsync_in;
        vsync_d  = vsync_in;
        if (!disp_q)                rgb_d = RGB_BLACK;
        else if (in_x_q && in_y_q)  rgb_d = BALL_RGB;
        else if (border_q)          rgb_d = BORDER_RGB;
        else                        rgb_d = RGB_BLACK;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_x_q   <= 1'b0;
            in_y_q   <= 1'b0;
            border_q <= 1'b0;
            disp_q   <= 1'b0;
            hsync_q  <= 1'b0;
            vsync_q  <= 1'b0;
            rgb_q    <= '0;
        end else begin
            in_x_q   <= in_x_d;
            in_y_q   <= in_y_d;
            border_q <= border_d;
            disp_q   <= disp_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            rgb_q    <= rgb_d;
        end
    end

    assign hsync = hsync_q;
    assign vsync = vsync_q;
    assign rgb   = rgb_q;

endmodule

// File: tb/tb_ball_renderer.sv
// Self-checking bench for ball_renderer: pixel vectors via an output scoreboard, frame
// stepping against a position model, and reset/double-tick corner sequences.
module tb_ball_renderer;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] hpos, vpos;
    logic       display_on, hsync_in, vsync_in;
    logic       hsync_a, vsync_a, hsync_b, vsync_b;
    logic [2:0] rgb_a, rgb_b;
    logic [9:0] ball_x_a, ball_y_a, ball_x_b, ball_y_b;
`ifdef BALL_HIT_COUNT_EN
    logic [7:0] hit_a, hit_b;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ball_renderer dut_a (
        .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos), .display_on(display_on),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .hsync(hsync_a), .vsync(vsync_a),
        .rgb(rgb_a), .ball_x(ball_x_a), .ball_y(ball_y_a)
`ifdef BALL_HIT_COUNT_EN
        , .hit_count(hit_a)
`endif
    );

    ball_renderer #(.H_DISPLAY(480), .V_DISPLAY(480), .X_SPEED(4), .Y_SPEED(4)) dut_b (
        .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos), .display_on(display_on),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .hsync(hsync_b), .vsync(vsync_b),
        .rgb(rgb_b), .ball_x(ball_x_b), .ball_y(ball_y_b)
`ifdef BALL_HIT_COUNT_EN
        , .hit_count(hit_b)
`endif
    );

    typedef struct {
        int         h;
        int         v;
        logic [2:0] rgb;
        logic       hs;
        logic       vs;
    } exp_t;

    typedef struct {
        int         h;
        int         v;
        logic       disp;
        logic [2:0] rgb;
    } vec_t;

    exp_t exp_q[$];
    int   prev_h = 0, prev_v = 0;

    // Position model: a = 640x480 speed 2/1, b = 480x480 speed 4/4, both 16-pixel ball.
    int mx_a, my_a, mx_b, my_b, hits_a, hits_b;
    bit nx_neg_a, ny_neg_a, nx_neg_b, ny_neg_b;

    function automatic logic hs_of(input int h);
        return (h >= 658) && (h <= 749);
    endfunction

    function automatic logic vs_of(input int v);
        return (v >= 490) && (v <= 491);
    endfunction

    function automatic logic [2:0] rgb_model(input int h, input int v, input logic disp,
                                             input int bx, input int by);
        logic [9:0] ox, oy;
        ox = 10'(h) - 10'(bx);
        oy = 10'(v) - 10'(by);
        if (!disp) return 3'b000;
        if (ox < 10'd16 && oy < 10'd16) return 3'b111;
        if (h == 0 || h == 639 || v == 0 || v == 479) return 3'b010;
        return 3'b000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic axis(input int p, input bit neg, input int spd, input int mx,
                        output int np, output bit nneg, output bit hit);
        int n;
        n    = neg ? p - spd : p + spd;
        np   = n;
        nneg = neg;
        hit  = 1'b0;
        if (n < 0) begin
            np = 0;  nneg = 1'b0; hit = 1'b1;
        end else if (n > mx) begin
            np = mx; nneg = 1'b1; hit = 1'b1;
        end
    endtask

    task automatic model_reset();
        mx_a = 312; my_a = 232; mx_b = 232; my_b = 232;
        nx_neg_a = 0; ny_neg_a = 0; nx_neg_b = 0; ny_neg_b = 0;
        hits_a = 0; hits_b = 0;
    endtask

    task automatic model_tick();
        bit hx, hy;
        axis(mx_a, nx_neg_a, 2, 624, mx_a, nx_neg_a, hx);
        axis(my_a, ny_neg_a, 1, 464, my_a, ny_neg_a, hy);
        if ((hx || hy) && hits_a < 255) hits_a++;
        axis(mx_b, nx_neg_b, 4, 464, mx_b, nx_neg_b, hx);
        axis(my_b, ny_neg_b, 4, 464, my_b, ny_neg_b, hy);
        if ((hx || hy) && hits_b < 255) hits_b++;
    endtask

    // One pixel clock: retire the entry due now, then drive the next beam position.
    task automatic step(input int h, input int v, input logic disp, input logic [2:0] exp_rgb);
        exp_t e;
        @(posedge clk);
        #1;
        if (exp_q.size() >= 2) begin
            e = exp_q.pop_front();
            check($sformatf("rgb h%0d v%0d", e.h, e.v), 32'(rgb_a), 32'(e.rgb));
            check($sformatf("hsync h%0d", e.h), 32'(hsync_a), 32'(e.hs));
            check($sformatf("vsync v%0d", e.v), 32'(vsync_a), 32'(e.vs));
        end
        hpos       = 10'(h);
        vpos       = 10'(v);
        display_on = disp;
        hsync_in   = hs_of(prev_h);
        vsync_in   = vs_of(prev_v);
        prev_h     = h;
        prev_v     = v;
        exp_q.push_back('{h: h, v: v, rgb: exp_rgb, hs: hs_of(h), vs: vs_of(v)});
    endtask

    task automatic check_balls(input string tag);
        check({tag, " ball_x_a"}, 32'(ball_x_a), 32'(mx_a));
        check({tag, " ball_y_a"}, 32'(ball_y_a), 32'(my_a));
        check({tag, " ball_x_b"}, 32'(ball_x_b), 32'(mx_b));
        check({tag, " ball_y_b"}, 32'(ball_y_b), 32'(my_b));
`ifdef BALL_HIT_COUNT_EN
        check({tag, " hit_a"}, 32'(hit_a), 32'(hits_a));
        check({tag, " hit_b"}, 32'(hit_b), 32'(hits_b));
`endif
    endtask

    // Tick at (0,480), then three blanking pixels until MOVE/BOUNCE have updated the ball.
    task automatic tick_frame();
        step(0, 480, 1'b0, 3'b000);
        step(1, 480, 1'b0, 3'b000);
        step(2, 480, 1'b0, 3'b000);
        step(3, 480, 1'b0, 3'b000);
        model_tick();
    endtask

    vec_t tbl [0:17] = '{
        '{300, 232, 1'b1, 3'b000}, '{311, 232, 1'b1, 3'b000}, '{312, 232, 1'b1, 3'b111},
        '{320, 232, 1'b1, 3'b111}, '{327, 232, 1'b1, 3'b111}, '{328, 232, 1'b1, 3'b000},
        '{312, 231, 1'b1, 3'b000}, '{312, 247, 1'b1, 3'b111}, '{312, 248, 1'b1, 3'b000},
        '{  0,  10, 1'b1, 3'b010}, '{639,  10, 1'b1, 3'b010}, '{100,   0, 1'b1, 3'b010},
        '{100, 479, 1'b1, 3'b010}, '{312, 232, 1'b0, 3'b000}, '{640, 232, 1'b0, 3'b000},
        '{799, 232, 1'b0, 3'b000}, '{312, 480, 1'b0, 3'b000}, '{  0, 232, 1'b1, 3'b010}
    };

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; hpos = '0; vpos = '0; display_on = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
        model_reset();
        #12;
        check("reset rgb", 32'(rgb_a), 32'd0);
        check("reset hsync", 32'(hsync_a), 32'd0);
        check("reset vsync", 32'(vsync_a), 32'd0);
        check_balls("reset");
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 18; i++) step(tbl[i].h, tbl[i].v, tbl[i].disp, tbl[i].rgb);
        for (int h = 655; h <= 752; h++) step(h, 10, 1'b0, 3'b000);
        for (int v = 487; v <= 494; v++) step(100, v, 1'b0, 3'b000);

        for (int t = 1; t <= 158; t++) begin
            tick_frame();
            check_balls($sformatf("frame%0d", t));
            if (t == 58) begin
                check("f58 b x", 32'(ball_x_b), 32'd464);
                check("f58 b y", 32'(ball_y_b), 32'd464);
            end
            if (t == 59) begin
                check("f59 b x clamp", 32'(ball_x_b), 32'd464);
                check("f59 b y clamp", 32'(ball_y_b), 32'd464);
`ifdef BALL_HIT_COUNT_EN
                check("f59 b corner hit", 32'(hit_b), 32'd1);
`endif
            end
            if (t == 60) begin
                check("f60 b x", 32'(ball_x_b), 32'd460);
                check("f60 b y", 32'(ball_y_b), 32'd460);
            end
            if (t == 156) check("f156 a x", 32'(ball_x_a), 32'd624);
            if (t == 157) begin
                check("f157 a x clamp", 32'(ball_x_a), 32'd624);
`ifdef BALL_HIT_COUNT_EN
                check("f157 a hit", 32'(hit_a), 32'd1);
`endif
            end
            if (t == 158) check("f158 a x", 32'(ball_x_a), 32'd622);
        end

        // Visible pixels around the moved ball.
        step(mx_a - 1,  my_a, 1'b1, rgb_model(mx_a - 1,  my_a, 1'b1, mx_a, my_a));
        step(mx_a,      my_a, 1'b1, rgb_model(mx_a,      my_a, 1'b1, mx_a, my_a));
        step(mx_a + 15, my_a, 1'b1, rgb_model(mx_a + 15, my_a, 1'b1, mx_a, my_a));
        step(mx_a + 16, my_a, 1'b1, rgb_model(mx_a + 16, my_a, 1'b1, mx_a, my_a));

        // Second tick pulse arrives while the sequencer is in MOVE and must be ignored.
        step(0, 480, 1'b0, 3'b000);
        step(0, 480, 1'b0, 3'b000);
        step(1, 480, 1'b0, 3'b000);
        step(2, 480, 1'b0, 3'b000);
        step(3, 480, 1'b0, 3'b000);
        model_tick();
        check_balls("double tick");

        // Reset mid-line with all pixel outputs active.
        exp_q.delete();
        @(posedge clk); #1;
        hpos = 10'd0; vpos = 10'd100; display_on = 1'b1; hsync_in = 1'b1; vsync_in = 1'b1;
        @(posedge clk); #1;
        hpos = 10'd1;
        @(posedge clk); #1;
        check("pre-reset rgb", 32'(rgb_a), 32'd2);
        check("pre-reset hsync", 32'(hsync_a), 32'd1);
        check("pre-reset vsync", 32'(vsync_a), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("mid reset rgb", 32'(rgb_a), 32'd0);
        check("mid reset hsync", 32'(hsync_a), 32'd0);
        check("mid reset vsync", 32'(vsync_a), 32'd0);
        model_reset();
        check_balls("mid reset");
        @(posedge clk);
        @(negedge clk);
        hsync_in = 1'b0; vsync_in = 1'b0; prev_h = 0; prev_v = 0;
        reset = 1'b0;
        check_balls("after release");
        tick_frame();
        check_balls("post-reset frame");
        check("post-reset a x", 32'(ball_x_a), 32'd314);
        check("post-reset a y", 32'(ball_y_a), 32'd233);
        step(mx_a, my_a, 1'b1, rgb_model(mx_a, my_a, 1'b1, mx_a, my_a));
        step(10, 10, 1'b1, 3'b000);
        step(10, 10, 1'b1, 3'b000);
        step(10, 10, 1'b1, 3'b000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
